// File: rtl/sd_data_tx.sv
// rtl/sd_data_tx.sv - SD 1-bit DAT0 write-block transmitter with CRC16 and status/busy handling
// One block per start: start bit, data MSB-first, CRC16, end bit, then CRC status token and busy.

module sd_crc16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic        din_i,
  output logic [15:0] crc_o
);
  logic [15:0] crc_q, crc_d;
  logic        fb;

  // CRC-16/CCITT (x^16 + x^12 + x^5 + 1), zero seed, one bit per enable
  assign fb = din_i ^ crc_q[15];

  always_comb begin
    crc_d = crc_q;
    if (clr_i)     crc_d = '0;
    else if (en_i) crc_d = {crc_q[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) crc_q <= '0;
    else     crc_q <= crc_d;
  end

  assign crc_o = crc_q;
endmodule

module sd_data_tx #(
  parameter int BLOCK_BYTES  = 512,
  parameter int STAT_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       bit_stb,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       starved,
  output logic       dat_out,
  output logic       dat_oe,
  input  logic       dat_in,
  output logic       active,
  output logic       done,
  output logic [2:0] status,
  output logic       status_ok,
  output logic       err_timeout
);
  localparam int BW = $clog2(BLOCK_BYTES + 1);
  localparam int TW = $clog2(STAT_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_DATA, S_CRC, S_END, S_SWAIT, S_STAT, S_BUSY
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    hold_q, hold_d, shift_q, shift_d;
  logic          hold_full_q, hold_full_d;
  logic [BW-1:0] acc_cnt_q, acc_cnt_d, tx_cnt_q, tx_cnt_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          released_q, released_d;
  logic          dat_out_q, dat_out_d, dat_oe_q, dat_oe_d, done_q, done_d;
  logic [2:0]    status_q, status_d;
  logic          ok_q, ok_d, err_q, err_d;

  logic          crc_clr, crc_en;
  logic [15:0]   crc_val;
  logic          accept, byte_avail, data_adv, tx_bit, last_data_bit, byte_edge;
  logic [7:0]    src_byte;

  sd_crc16 u_crc (
    .clk   (clk),
    .rst   (reset),
    .clr_i (crc_clr),
    .en_i  (crc_en),
    .din_i (tx_bit),
    .crc_o (crc_val)
  );

  assign in_ready   = (state_q != S_IDLE) && !hold_full_q && (acc_cnt_q < BW'(BLOCK_BYTES));
  assign accept     = in_valid && in_ready;
  // A byte accepted in the very cycle it is needed bypasses the holding register
  assign src_byte   = hold_full_q ? hold_q : in_data;
  assign byte_avail = hold_full_q || accept;
  assign byte_edge  = (bit_cnt_q == 4'd0);
  assign starved    = (state_q == S_DATA) && bit_stb && byte_edge && !byte_avail;
  assign data_adv   = (state_q == S_DATA) && bit_stb && !starved;
  assign tx_bit     = byte_edge ? src_byte[7] : shift_q[7];
  assign last_data_bit = (bit_cnt_q == 4'd7) && (tx_cnt_q == BW'(BLOCK_BYTES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_PRE;
      S_PRE:   if (bit_stb) state_d = S_DATA;
      S_DATA:  if (data_adv && last_data_bit) state_d = S_CRC;
      S_CRC:   if (bit_stb && bit_cnt_q == 4'd15) state_d = S_END;
      S_END:   if (bit_stb) state_d = S_SWAIT;
      S_SWAIT: if (bit_stb && released_q) begin
        if (!dat_in) state_d = S_STAT;
        else if (tmo_q == TW'(STAT_TIMEOUT - 1)) state_d = S_IDLE;
      end
      S_STAT:  if (bit_stb && bit_cnt_q == 4'd3) state_d = S_BUSY;
      S_BUSY:  if (bit_stb && dat_in) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    acc_cnt_d   = acc_cnt_q;
    tx_cnt_d    = tx_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    tmo_d       = tmo_q;
    released_d  = released_q;
    dat_out_d   = dat_out_q;
    dat_oe_d    = dat_oe_q;
    done_d      = 1'b0;
    status_d    = status_q;
    ok_d        = ok_q;
    err_d       = err_q;
    crc_clr     = 1'b0;
    crc_en      = 1'b0;

    if (accept) begin
      acc_cnt_d = acc_cnt_q + 1'b1;
      if (!(data_adv && byte_edge)) begin
        hold_d      = in_data;
        hold_full_d = 1'b1;
      end
    end
    if (data_adv && byte_edge && hold_full_q) hold_full_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        dat_oe_d  = 1'b0;
        dat_out_d = 1'b1;
        if (start) begin
          crc_clr     = 1'b1;
          dat_oe_d    = 1'b1;
          hold_full_d = 1'b0;
          acc_cnt_d   = '0;
          tx_cnt_d    = '0;
          bit_cnt_d   = '0;
          tmo_d       = '0;
          released_d  = 1'b0;
          status_d    = '0;
          ok_d        = 1'b0;
          err_d       = 1'b0;
        end
      end
      S_PRE: if (bit_stb) dat_out_d = 1'b0;
      S_DATA: if (data_adv) begin
        dat_out_d = tx_bit;
        crc_en    = 1'b1;
        shift_d   = byte_edge ? {src_byte[6:0], 1'b0} : {shift_q[6:0], 1'b0};
        if (bit_cnt_q == 4'd7) begin
          bit_cnt_d = '0;
          tx_cnt_d  = last_data_bit ? '0 : tx_cnt_q + 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
      S_CRC: if (bit_stb) begin
        dat_out_d = crc_val[4'd15 - bit_cnt_q];
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
      S_END: if (bit_stb) dat_out_d = 1'b1;
      S_SWAIT: if (bit_stb) begin
        if (!released_q) begin
          dat_oe_d   = 1'b0;
          released_d = 1'b1;
          tmo_d      = '0;
        end else if (dat_in) begin
          if (tmo_q == TW'(STAT_TIMEOUT - 1)) begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
      end
      S_STAT: if (bit_stb) begin
        if (bit_cnt_q != 4'd3) status_d = {status_q[1:0], dat_in};
        bit_cnt_d = (bit_cnt_q == 4'd3) ? 4'd0 : bit_cnt_q + 4'd1;
      end
      S_BUSY: if (bit_stb && dat_in) begin
        done_d = 1'b1;
        ok_d   = (status_q == 3'b010);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      acc_cnt_q   <= '0;
      tx_cnt_q    <= '0;
      bit_cnt_q   <= '0;
      tmo_q       <= '0;
      released_q  <= 1'b0;
      dat_out_q   <= 1'b1;
      dat_oe_q    <= 1'b0;
      done_q      <= 1'b0;
      status_q    <= '0;
      ok_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      acc_cnt_q   <= acc_cnt_d;
      tx_cnt_q    <= tx_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      tmo_q       <= tmo_d;
      released_q  <= released_d;
      dat_out_q   <= dat_out_d;
      dat_oe_q    <= dat_oe_d;
      done_q      <= done_d;
      status_q    <= status_d;
      ok_q        <= ok_d;
      err_q       <= err_d;
    end
  end

  assign dat_out     = dat_out_q;
  assign dat_oe      = dat_oe_q;
  assign active      = (state_q != S_IDLE);
  assign done        = done_q;
  assign status      = status_q;
  assign status_ok   = ok_q;
  assign err_timeout = err_q;
endmodule

// File: tb/tb_sd_data_tx.sv
// tb/tb_sd_data_tx.sv - self-checking bench for sd_data_tx (512-byte and 4-byte instances)
module tb_sd_data_tx;
  localparam int BIG = 512, SMALL = 4, TMO = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_b = 1'b1, rst_s = 1'b1, sel_s = 1'b0;
  logic start = 1'b0, bit_stb = 1'b0, in_valid = 1'b0, dat_in = 1'b1;
  logic [7:0] in_data = 8'h00;

  logic b_in_ready, b_starved, b_dat_out, b_dat_oe, b_active, b_done, b_ok, b_err;
  logic s_in_ready, s_starved, s_dat_out, s_dat_oe, s_active, s_done, s_ok, s_err;
  logic [2:0] b_status, s_status;

  sd_data_tx #(.BLOCK_BYTES(BIG), .STAT_TIMEOUT(TMO)) u_big (
    .clk(clk), .reset(rst_b), .start(start), .bit_stb(bit_stb), .in_data(in_data),
    .in_valid(in_valid), .in_ready(b_in_ready), .starved(b_starved), .dat_out(b_dat_out),
    .dat_oe(b_dat_oe), .dat_in(dat_in), .active(b_active), .done(b_done),
    .status(b_status), .status_ok(b_ok), .err_timeout(b_err));

  sd_data_tx #(.BLOCK_BYTES(SMALL), .STAT_TIMEOUT(TMO)) u_small (
    .clk(clk), .reset(rst_s), .start(start), .bit_stb(bit_stb), .in_data(in_data),
    .in_valid(in_valid), .in_ready(s_in_ready), .starved(s_starved), .dat_out(s_dat_out),
    .dat_oe(s_dat_oe), .dat_in(dat_in), .active(s_active), .done(s_done),
    .status(s_status), .status_ok(s_ok), .err_timeout(s_err));

  // The unselected instance is held in reset; all observation goes through these
  wire       m_in_ready = sel_s ? s_in_ready : b_in_ready;
  wire       m_starved  = sel_s ? s_starved  : b_starved;
  wire       m_dat_out  = sel_s ? s_dat_out  : b_dat_out;
  wire       m_dat_oe   = sel_s ? s_dat_oe   : b_dat_oe;
  wire       m_active   = sel_s ? s_active   : b_active;
  wire       m_done     = sel_s ? s_done     : b_done;
  wire [2:0] m_status   = sel_s ? s_status   : b_status;
  wire       m_ok       = sel_s ? s_ok       : b_ok;
  wire       m_err      = sel_s ? s_err      : b_err;

  int n_pass = 0, n_total = 0;
  byte blk[$], feed[$];
  bit  exp_bits[$], cap[$], ref_cap[$], card[$];
  logic [15:0] exp_crc;
  int n_bytes, period, phase, eff, done_cnt, done_at, starved_cnt, frozen_err, oe_low, accepted;
  int stall_byte = -1, stall_left = 0, poke_eff = -1;
  bit stb_en, force_stb, start_now, running, stb_eff_pend, starved_pend, poked;
  logic oe_rel, last_dat;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // Reference CRC: message * x^16 mod G by long division
  function automatic logic [15:0] crc16_of(input byte d[$]);
    logic [15:0] rem = '0;
    logic top, m;
    for (int i = 0; i < d.size() + 2; i++)
      for (int b = 7; b >= 0; b--) begin
        m   = (i < d.size()) ? d[i][b] : 1'b0;
        top = rem[15];
        rem = {rem[14:0], m};
        if (top) rem = rem ^ 16'h1021;
      end
    return rem;
  endfunction

  function automatic int diff_count(input bit a[$], input bit b[$]);
    int n = (a.size() > b.size()) ? a.size() - b.size() : b.size() - a.size();
    for (int i = 0; i < a.size() && i < b.size(); i++) if (a[i] != b[i]) n++;
    return n;
  endfunction

  function automatic logic [15:0] cap_crc();
    logic [15:0] v = 'x;
    if (cap.size() == 8 * n_bytes + 18)
      for (int i = 0; i < 16; i++) v[15-i] = cap[8 * n_bytes + 1 + i];
    return v;
  endfunction

  task automatic prep();
    feed = blk;
    exp_crc = crc16_of(blk);
    exp_bits.delete();
    exp_bits.push_back(1'b0);
    foreach (blk[i]) for (int b = 7; b >= 0; b--) exp_bits.push_back(blk[i][b]);
    for (int b = 15; b >= 0; b--) exp_bits.push_back(exp_crc[b]);
    exp_bits.push_back(1'b1);
  endtask

  task automatic rand_blk(input int n);
    blk.delete();
    repeat (n) blk.push_back(8'($urandom));
  endtask

  task automatic card_status(input int lead, input logic [2:0] st, input int busy);
    card.delete();
    repeat (lead) card.push_back(1'b1);
    card.push_back(1'b0);
    for (int b = 2; b >= 0; b--) card.push_back(st[b]);
    card.push_back(1'b1);
    repeat (busy) card.push_back(1'b0);
    card.push_back(1'b1);
  endtask

  // One clock cycle: observe the previous edge's effects, then drive the next cycle's inputs
  task automatic tick();
    int  k;
    bit  poke;
    @(negedge clk);
    if (stb_eff_pend) begin
      if (eff <= 8 * n_bytes + 17) begin
        cap.push_back(m_dat_out);
        if (m_dat_oe !== 1'b1) oe_low++;
      end
      if (eff == 8 * n_bytes + 18) oe_rel = m_dat_oe;
      eff++;
    end
    if (starved_pend && m_dat_out !== last_dat) frozen_err++;
    if (m_done === 1'b1) begin
      done_cnt++;
      if (done_cnt == 1) done_at = eff;
    end
    if (stb_en) phase = (phase + 1) % period;
    bit_stb = (stb_en && phase == 0) || force_stb;
    poke = (eff == poke_eff) && !poked;
    if (poke) poked = 1'b1;
    start = start_now || poke;
    in_valid = (feed.size() > 0) && !(accepted == stall_byte && stall_left > 0);
    in_data  = in_valid ? feed[0] : 8'($urandom);
    k = eff - (8 * n_bytes + 19);
    dat_in = (k < 0) ? 1'($urandom) : ((k < card.size()) ? card[k] : 1'b1);
    #1;
    last_dat     = m_dat_out;
    starved_pend = (m_starved === 1'b1);
    if (starved_pend) starved_cnt++;
    stb_eff_pend = bit_stb && !starved_pend && !start_now && running;
    if (accepted == stall_byte && stall_left > 0 && bit_stb && m_in_ready) stall_left--;
    if (in_valid && m_in_ready) begin
      void'(feed.pop_front());
      accepted++;
    end
  endtask

  task automatic begin_block(input int nb, input int per);
    n_bytes = nb; period = per; phase = 0; eff = 0; cap.delete();
    done_cnt = 0; done_at = -1; starved_cnt = 0; frozen_err = 0; oe_low = 0; accepted = 0;
    stb_eff_pend = 0; starved_pend = 0; poked = 0; oe_rel = 1'bx;
    start_now = 1; stb_en = 1; running = 1;
    tick();
    start_now = 0; force_stb = 0;
  endtask

  task automatic run_block(input int nb, input int per, input int max_cyc);
    begin_block(nb, per);
    for (int c = 0; c < max_cyc && done_cnt == 0; c++) tick();
    tick(); tick();
    running = 0; stb_en = 0;
  endtask

  task automatic check_block(input string tg, input logic [2:0] st, input logic ok,
                             input logic err, input int exp_done);
    check({tg, "_len"}, cap.size(), exp_bits.size());
    check({tg, "_bits"}, diff_count(cap, exp_bits), 0);
    check({tg, "_oe_tx"}, oe_low, 0);
    check({tg, "_oe_rel"}, oe_rel, 1'b0);
    check({tg, "_done_at"}, done_at, exp_done);
    check({tg, "_done_w"}, done_cnt, 1);
    check({tg, "_status"}, m_status, st);
    check({tg, "_ok"}, m_ok, ok);
    check({tg, "_err"}, m_err, err);
    check({tg, "_active"}, m_active, 1'b0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    check("rst_oe", m_dat_oe, 1'b0);
    check("rst_out", m_dat_out, 1'b1);
    check("rst_ready", m_in_ready, 1'b0);
    check("rst_active", m_active, 1'b0);
    check("rst_done", m_done, 1'b0);
    check("rst_flags", {m_status, m_ok, m_err, m_starved}, 6'd0);
    rst_b = 1'b0;
    tick();
    check("idle_ready", m_in_ready, 1'b0);
    check("idle_out", {m_dat_oe, m_dat_out}, 2'b01);

    // 512 x 0xFF, stb every 4 clk, status 010 after two idle bits, 8 busy cycles
    blk.delete();
    repeat (BIG) blk.push_back(8'hFF);
    prep();
    card_status(2, 3'b010, 8);
    run_block(BIG, 4, 20000);
    check_block("ff", 3'b010, 1'b1, 1'b0, 8 * BIG + 19 + card.size());
    check("ff_crc", cap_crc(), 16'h7FA1);

    // Reset around byte 100, then a fresh random block
    rand_blk(BIG);
    prep();
    card.delete();
    begin_block(BIG, 2);
    for (int c = 0; c < 5000 && eff < 801; c++) tick();
    check("mid_reach", eff >= 801, 1'b1);
    #2 rst_b = 1'b1;
    #1;
    check("mid_oe", m_dat_oe, 1'b0);
    check("mid_active", m_active, 1'b0);
    check("mid_out", m_dat_out, 1'b1);
    stb_en = 0; running = 0; feed.delete();
    tick(); tick();
    rst_b = 1'b0;
    tick();
    rand_blk(BIG);
    prep();
    card_status(0, 3'b010, 3);
    run_block(BIG, 2, 12000);
    check_block("fresh", 3'b010, 1'b1, 1'b0, 8 * BIG + 19 + card.size());
    check("fresh_crc", cap_crc(), exp_crc);

    // Switch to the 4-byte instance
    sel_s = 1'b1; rst_b = 1'b1;
    tick();
    rst_s = 1'b0;
    tick();

    blk.delete();
    repeat (SMALL) blk.push_back(8'h00);
    prep();
    card_status(0, 3'b101, 3);
    run_block(SMALL, 3, 2000);
    check_block("zero", 3'b101, 1'b0, 1'b0, 8 * SMALL + 19 + card.size());
    check("zero_crc", cap_crc(), 16'h0000);

    rand_blk(SMALL);
    prep();
    card_status(1, 3'b010, 2);
    run_block(SMALL, 3, 2000);
    check_block("nostall", 3'b010, 1'b1, 1'b0, 8 * SMALL + 19 + card.size());
    ref_cap = cap;

    prep();
    stall_byte = 2; stall_left = 10;
    run_block(SMALL, 3, 2000);
    stall_byte = -1;
    check_block("stall", 3'b010, 1'b1, 1'b0, 8 * SMALL + 19 + card.size());
    check("stall_seen", starved_cnt > 0, 1'b1);
    check("stall_frozen", frozen_err, 0);
    check("stall_same", diff_count(cap, ref_cap), 0);

    rand_blk(SMALL);
    prep();
    card.delete();
    run_block(SMALL, 2, 2000);
    check_block("tmo", 3'b000, 1'b0, 1'b1, 8 * SMALL + 19 + TMO);
    check("tmo_oe", m_dat_oe, 1'b0);

    // start coincident with stb in IDLE, and a stray start during BUSY
    rand_blk(SMALL);
    prep();
    card_status(0, 3'b010, 20);
    poke_eff = 8 * SMALL + 19 + 11;
    force_stb = 1;
    run_block(SMALL, 2, 2000);
    poke_eff = -1;
    check_block("poke", 3'b010, 1'b1, 1'b0, 8 * SMALL + 19 + card.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
